// File: rtl/sysarr_buf_pkg.sv
// Shared definitions for the systolic-array operand lane buffer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sysarr_buf_pkg;

   // Operating mode of the lane buffer, one operation per cycle.
   typedef enum logic [1:0] {
      MODE_IDLE  = 2'b00,
      MODE_LOAD  = 2'b01,
      MODE_DRAIN = 2'b10,
      MODE_FLUSH = 2'b11
   } mode_t;

   localparam int DEFAULT_DATA_W = 16;

endpackage

// File: rtl/lane_skew_delay.sv
// Per-lane delay line of {valid, data} used to skew one lane of a row.
// Latency: DELAY cycles (DELAY=0 is a pure wire).
// Backpressure: none; shifts every cycle, cleared synchronously by rst or i_flush.
//
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   i_flush    synchronous clear of every stage
//   i_vld      valid entering the line
//   i_dat      data entering the line
//   o_vld      valid leaving the line
//   o_dat      data leaving the line, forced to 0 when o_vld is low
module lane_skew_delay #(
   parameter int DATA_W = 16,
   parameter int DELAY  = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_flush,
   input  logic              i_vld,
   input  logic [DATA_W-1:0] i_dat,
   output logic              o_vld,
   output logic [DATA_W-1:0] o_dat
);

   generate
      if (DELAY == 0) begin : g_pass
         // The upstream stage-0 register already provides the clear,
         // so the control inputs have no work to do in this case.
         logic w_unused_ctrl;
         assign w_unused_ctrl = ^{clk, rst, i_flush};

         assign o_vld = i_vld;
         assign o_dat = i_vld ? i_dat : '0;
      end else begin : g_delay
         logic [DELAY-1:0] r_vld;
         logic [DATA_W-1:0] r_dat [DELAY];

         always_ff @(posedge clk) begin
            if (rst || i_flush) begin
               r_vld <= '0;
               for (int k = 0; k < DELAY; k++) begin
                  r_dat[k] <= '0;
               end
            end else begin
               r_vld[0] <= i_vld;
               r_dat[0] <= i_vld ? i_dat : '0;
               for (int k = 1; k < DELAY; k++) begin
                  r_vld[k] <= r_vld[k-1];
                  r_dat[k] <= r_dat[k-1];
               end
            end
         end

         assign o_vld = r_vld[DELAY-1];
         assign o_dat = r_vld[DELAY-1] ? r_dat[DELAY-1] : '0;
      end
   endgenerate

endmodule

// File: rtl/skewed_lane_buffer.sv
// Multi-lane row FIFO feeding one edge of the systolic array, with per-lane skew.
// Latency: lane i shows a popped row 1+i edges after the pop (1 edge for all lanes when SKEW_EN=0).
// Backpressure: none; writes when full are dropped (sticky overflow), pops when empty bubble (sticky underflow).
//
// Ports:
//   clk, rst    clock and synchronous active-high reset (rst overrides mode)
//   mode        00 IDLE, 01 LOAD, 10 DRAIN, 11 FLUSH
//   in_valid    qualifies in_data in LOAD mode
//   in_data     input row, lane i at [i*DATA_W +: DATA_W]
//   out_data    skewed output row, same packing; invalid lanes read 0
//   out_valid   per-lane valid for out_data
//   full/empty  combinational from count
//   count       rows stored
//   overflow    sticky: write attempted while full
//   underflow   sticky: pop attempted while empty
module skewed_lane_buffer
   import sysarr_buf_pkg::*;
#(
   parameter int DATA_W    = DEFAULT_DATA_W,
   parameter int NUM_LANES = 4,
   parameter int DEPTH     = 8,
   parameter bit SKEW_EN   = 1'b1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [1:0]                    mode,
   input  logic                          in_valid,
   input  logic [NUM_LANES*DATA_W-1:0]   in_data,
   output logic [NUM_LANES*DATA_W-1:0]   out_data,
   output logic [NUM_LANES-1:0]          out_valid,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(DEPTH):0]        count,
   output logic                          overflow,
   output logic                          underflow
);

   localparam int AW    = $clog2(DEPTH);
   localparam int ROW_W = NUM_LANES * DATA_W;

   // Pointers wrap by comparison so DEPTH need not be a power of two.
   localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
   localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

   function automatic logic [AW-1:0] f_next_ptr(input logic [AW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + AW'(1);
   endfunction

   mode_t            w_mode;
   logic             w_flush;
   logic             w_full;
   logic             w_empty;
   logic             w_wr_req;
   logic             w_rd_req;
   logic             w_wr_en;
   logic             w_rd_en;

   logic [ROW_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_head;
   logic [AW-1:0]    r_tail;
   logic [AW:0]      r_count;
   logic             r_overflow;
   logic             r_underflow;

   // Common stage 0: the popped row (or a zero bubble) lands here at the pop edge.
   logic             r_s0_vld;
   logic [ROW_W-1:0] r_s0_dat;

   assign w_mode   = mode_t'(mode);
   assign w_flush  = (w_mode == MODE_FLUSH);
   assign w_full   = (r_count == FULL_CNT);
   assign w_empty  = (r_count == '0);
   assign w_wr_req = (w_mode == MODE_LOAD) && in_valid;
   assign w_rd_req = (w_mode == MODE_DRAIN);
   assign w_wr_en  = w_wr_req && !w_full;
   assign w_rd_en  = w_rd_req && !w_empty;

   // Row storage carries no reset; only the pointers define what is live.
   always_ff @(posedge clk) begin
      if (!rst && w_wr_en) begin
         r_mem[r_tail] <= in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || w_flush) begin
         r_head      <= '0;
         r_tail      <= '0;
         r_count     <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
         r_s0_vld    <= 1'b0;
         r_s0_dat    <= '0;
      end else begin
         // Anything other than a successful pop injects a bubble.
         r_s0_vld <= 1'b0;
         r_s0_dat <= '0;

         if (w_wr_req) begin
            if (w_full) begin
               r_overflow <= 1'b1;
            end else begin
               r_tail  <= f_next_ptr(r_tail);
               r_count <= r_count + 1'b1;
            end
         end

         if (w_rd_req) begin
            if (w_empty) begin
               r_underflow <= 1'b1;
            end else begin
               r_s0_vld <= 1'b1;
               r_s0_dat <= r_mem[r_head];
               r_head   <= f_next_ptr(r_head);
               r_count  <= r_count - 1'b1;
            end
         end
      end
   end

   // w_rd_en is folded into the stage-0 update above; kept for readability of intent.
   logic w_unused_rd_en;
   assign w_unused_rd_en = w_rd_en;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
         localparam int LANE_DELAY = SKEW_EN ? gi : 0;

         lane_skew_delay #(
            .DATA_W (DATA_W),
            .DELAY  (LANE_DELAY)
         ) u_dly (
            .clk     (clk),
            .rst     (rst),
            .i_flush (w_flush),
            .i_vld   (r_s0_vld),
            .i_dat   (r_s0_dat[gi*DATA_W +: DATA_W]),
            .o_vld   (out_valid[gi]),
            .o_dat   (out_data[gi*DATA_W +: DATA_W])
         );
      end
   endgenerate

   assign full      = w_full;
   assign empty     = w_empty;
   assign count     = r_count;
   assign overflow  = r_overflow;
   assign underflow = r_underflow;

endmodule

// File: tb/tb_skewed_lane_buffer.sv
module tb_skewed_lane_buffer;
   import sysarr_buf_pkg::*;

   localparam int DW = 16;
   localparam int NL = 4;
   localparam int RW = DW * NL;
   localparam int DA = 8;
   localparam int DB = 5;
   localparam int HN = 2048;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic [1:0]    mode;
   logic          in_valid;
   logic [RW-1:0] in_data;

   logic [RW-1:0] a_od, b_od;
   logic [NL-1:0] a_ov, b_ov;
   logic          a_full, a_empty, a_ovf, a_udf;
   logic          b_full, b_empty, b_ovf, b_udf;
   logic [3:0]    a_cnt, b_cnt;

   skewed_lane_buffer #(.DATA_W(DW), .NUM_LANES(NL), .DEPTH(DA), .SKEW_EN(1'b1)) dut_a (
      .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_data(in_data),
      .out_data(a_od), .out_valid(a_ov), .full(a_full), .empty(a_empty),
      .count(a_cnt), .overflow(a_ovf), .underflow(a_udf));

   skewed_lane_buffer #(.DATA_W(DW), .NUM_LANES(NL), .DEPTH(DB), .SKEW_EN(1'b0)) dut_b (
      .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_data(in_data),
      .out_data(b_od), .out_valid(b_ov), .full(b_full), .empty(b_empty),
      .count(b_cnt), .overflow(b_ovf), .underflow(b_udf));

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;

   // Reference model: rows kept as an ordered list (index 0 = oldest),
   // plus a history of what was popped at each edge.
   logic [RW-1:0] mrow  [2][16];
   int            mcnt  [2];
   bit            movf  [2];
   bit            mudf  [2];
   int            mdisc [2];
   bit            hv    [2][HN];
   logic [RW-1:0] hd    [2][HN];
   int            mdepth[2] = '{DA, DB};
   bit            mskew [2] = '{1'b1, 1'b0};

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic model_edge(input bit r, input logic [1:0] m, input bit v, input logic [RW-1:0] d);
      for (int k = 0; k < 2; k++) begin
         hv[k][cyc] = 1'b0;
         hd[k][cyc] = '0;
         if (r || m == MODE_FLUSH) begin
            mcnt[k]  = 0;
            movf[k]  = 1'b0;
            mudf[k]  = 1'b0;
            mdisc[k] = cyc;
         end else if (m == MODE_LOAD && v) begin
            if (mcnt[k] == mdepth[k]) begin
               movf[k] = 1'b1;
            end else begin
               mrow[k][mcnt[k]] = d;
               mcnt[k]++;
            end
         end else if (m == MODE_DRAIN) begin
            if (mcnt[k] == 0) begin
               mudf[k] = 1'b1;
            end else begin
               hv[k][cyc] = 1'b1;
               hd[k][cyc] = mrow[k][0];
               for (int j = 0; j < 15; j++) mrow[k][j] = mrow[k][j+1];
               mcnt[k]--;
            end
         end
      end
   endtask

   task automatic model_check(input int k, input logic [RW-1:0] od, input logic [NL-1:0] ov,
                              input logic [3:0] cnt, input logic fl, input logic em,
                              input logic of, input logic uf);
      logic [RW-1:0] eod;
      logic [NL-1:0] eov;
      int c;
      eod = '0;
      eov = '0;
      for (int i = 0; i < NL; i++) begin
         c = cyc - (mskew[k] ? i : 0);
         if (c > mdisc[k] && c >= 0 && hv[k][c]) begin
            eov[i] = 1'b1;
            eod[i*DW +: DW] = hd[k][c][i*DW +: DW];
         end
      end
      chk($sformatf("m%0d_out_valid", k), 64'(ov), 64'(eov));
      chk($sformatf("m%0d_out_data", k), od, eod);
      chk($sformatf("m%0d_count", k), 64'(cnt), 64'(mcnt[k]));
      chk($sformatf("m%0d_full", k), 64'(fl), 64'(mcnt[k] == mdepth[k]));
      chk($sformatf("m%0d_empty", k), 64'(em), 64'(mcnt[k] == 0));
      chk($sformatf("m%0d_overflow", k), 64'(of), 64'(movf[k]));
      chk($sformatf("m%0d_underflow", k), 64'(uf), 64'(mudf[k]));
   endtask

   task automatic step(input bit r, input logic [1:0] m, input bit v, input logic [RW-1:0] d);
      rst      = r;
      mode     = m;
      in_valid = v;
      in_data  = d;
      @(posedge clk);
      cyc++;
      model_edge(r, m, v, d);
      #1;
      model_check(0, a_od, a_ov, a_cnt, a_full, a_empty, a_ovf, a_udf);
      model_check(1, b_od, b_ov, b_cnt, b_full, b_empty, b_ovf, b_udf);
   endtask

   function automatic logic [RW-1:0] mkrow(input int k);
      logic [RW-1:0] r;
      for (int i = 0; i < NL; i++) r[i*DW +: DW] = DW'(k * 16 + i);
      return r;
   endfunction

   function automatic logic [RW-1:0] rndrow();
      return {$urandom, $urandom};
   endfunction

   typedef struct {
      bit            r;
      logic [1:0]    m;
      bit            v;
      logic [RW-1:0] d;
      logic [3:0]    cnt;
      logic [NL-1:0] ov;
      logic [RW-1:0] od;
   } vec_t;

   vec_t tbl[13];

   initial begin
      for (int k = 0; k < 2; k++) begin
         mcnt[k] = 0; movf[k] = 0; mudf[k] = 0; mdisc[k] = -1;
      end
      rst = 1'b1; mode = MODE_IDLE; in_valid = 1'b0; in_data = '0;

      // Directed load/drain of R0..R3 on the skewed build.
      tbl[0]  = '{1'b1, MODE_IDLE,  1'b0, 64'h0,    4'd0, 4'b0000, 64'h0};
      tbl[1]  = '{1'b0, MODE_LOAD,  1'b1, mkrow(0), 4'd1, 4'b0000, 64'h0};
      tbl[2]  = '{1'b0, MODE_LOAD,  1'b1, mkrow(1), 4'd2, 4'b0000, 64'h0};
      tbl[3]  = '{1'b0, MODE_LOAD,  1'b1, mkrow(2), 4'd3, 4'b0000, 64'h0};
      tbl[4]  = '{1'b0, MODE_LOAD,  1'b1, mkrow(3), 4'd4, 4'b0000, 64'h0};
      tbl[5]  = '{1'b0, MODE_DRAIN, 1'b0, 64'h0,    4'd3, 4'b0001, 64'h0000_0000_0000_0000};
      tbl[6]  = '{1'b0, MODE_DRAIN, 1'b0, 64'h0,    4'd2, 4'b0011, 64'h0000_0000_0001_0010};
      tbl[7]  = '{1'b0, MODE_DRAIN, 1'b0, 64'h0,    4'd1, 4'b0111, 64'h0000_0002_0011_0020};
      tbl[8]  = '{1'b0, MODE_DRAIN, 1'b0, 64'h0,    4'd0, 4'b1111, 64'h0003_0012_0021_0030};
      tbl[9]  = '{1'b0, MODE_IDLE,  1'b0, 64'h0,    4'd0, 4'b1110, 64'h0013_0022_0031_0000};
      tbl[10] = '{1'b0, MODE_IDLE,  1'b0, 64'h0,    4'd0, 4'b1100, 64'h0023_0032_0000_0000};
      tbl[11] = '{1'b0, MODE_IDLE,  1'b0, 64'h0,    4'd0, 4'b1000, 64'h0033_0000_0000_0000};
      tbl[12] = '{1'b0, MODE_IDLE,  1'b0, 64'h0,    4'd0, 4'b0000, 64'h0};

      for (int i = 0; i < 13; i++) begin
         step(tbl[i].r, tbl[i].m, tbl[i].v, tbl[i].d);
         chk($sformatf("tbl%0d_count", i), 64'(a_cnt), 64'(tbl[i].cnt));
         chk($sformatf("tbl%0d_empty", i), 64'(a_empty), 64'(tbl[i].cnt == 4'd0));
         chk($sformatf("tbl%0d_out_valid", i), 64'(a_ov), 64'(tbl[i].ov));
         chk($sformatf("tbl%0d_out_data", i), a_od, tbl[i].od);
      end

      // Overflow: 9 writes into 8 rows; the 9th is dropped.
      step(0, MODE_FLUSH, 0, '0);
      for (int k = 0; k < 9; k++) begin
         step(0, MODE_LOAD, 1, rndrow());
         if (k == 7) begin
            chk("ovf_full_at_8", 64'(a_full), 64'd1);
            chk("ovf_not_yet", 64'(a_ovf), 64'd0);
         end
      end
      chk("ovf_set", 64'(a_ovf), 64'd1);
      chk("ovf_count8", 64'(a_cnt), 64'd8);
      for (int k = 0; k < 12; k++) step(0, MODE_DRAIN - ((k >= 8) ? 2'd2 : 2'd0), 0, '0);
      chk("ovf_drained_empty", 64'(a_empty), 64'd1);
      chk("ovf_sticky", 64'(a_ovf), 64'd1);

      // Underflow on an empty buffer, cleared by FLUSH.
      step(0, MODE_FLUSH, 0, '0);
      chk("flush_clears_ovf", 64'(a_ovf), 64'd0);
      step(0, MODE_DRAIN, 0, '0);
      step(0, MODE_DRAIN, 0, '0);
      chk("udf_set", 64'(a_udf), 64'd1);
      chk("udf_no_valid", 64'(a_ov), 64'd0);
      chk("udf_count0", 64'(a_cnt), 64'd0);
      step(0, MODE_FLUSH, 0, '0);
      chk("flush_clears_udf", 64'(a_udf), 64'd0);

      // Pointer wrap-around on both builds.
      for (int b = 0; b < 2; b++) begin
         for (int k = 0; k < 6; k++) step(0, MODE_LOAD, 1, rndrow());
         for (int k = 0; k < 6; k++) step(0, MODE_DRAIN, 0, '0);
         for (int k = 0; k < 4; k++) step(0, MODE_IDLE, 0, '0);
      end
      chk("wrap_empty", 64'(a_empty), 64'd1);

      // Aligned build: all lanes valid together one edge after the pop.
      step(0, MODE_FLUSH, 0, '0);
      step(0, MODE_LOAD, 1, 64'hA3A3_A2A2_A1A1_A0A0);
      step(0, MODE_DRAIN, 0, '0);
      chk("noskew_valid", 64'(b_ov), 64'hF);
      chk("noskew_data", b_od, 64'hA3A3_A2A2_A1A1_A0A0);
      chk("skew_lane0_only", 64'(a_ov), 64'h1);
      step(0, MODE_IDLE, 0, '0);
      chk("noskew_after", 64'(b_ov), 64'h0);

      // Reset two cycles after the first pop of a 3-row drain.
      step(0, MODE_FLUSH, 0, '0);
      for (int k = 0; k < 3; k++) step(0, MODE_LOAD, 1, rndrow());
      step(0, MODE_DRAIN, 0, '0);
      step(0, MODE_DRAIN, 0, '0);
      step(1, MODE_DRAIN, 0, '0);
      chk("rst_mid_valid", 64'(a_ov), 64'h0);
      chk("rst_mid_data", a_od, 64'h0);
      chk("rst_mid_count", 64'(a_cnt), 64'd0);
      for (int k = 0; k < 6; k++) begin
         step(0, MODE_IDLE, 0, '0);
         chk("rst_no_stale", 64'(a_ov), 64'h0);
      end

      // Randomized traffic in load-heavy and drain-heavy phases.
      for (int k = 0; k < 400; k++) begin
         logic [1:0] m;
         bit r;
         r = ($urandom_range(0, 150) == 0);
         if ($urandom_range(0, 60) == 0) m = MODE_FLUSH;
         else if ($urandom_range(0, 9) < (((k / 40) % 2 == 0) ? 7 : 3)) m = MODE_LOAD;
         else m = $urandom_range(0, 3) == 0 ? MODE_IDLE : MODE_DRAIN;
         step(r, m, $urandom_range(0, 4) != 0, rndrow());
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
